// File: rtl/wb_initiator_if.sv
// Command/response handshake plus Wishbone classic master signals for wb_initiator.
// The master modport is the initiator's view. The slave modport is the view of the environment around it.
interface wb_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator. It turns one command into one bus cycle and returns one response.
// When a slave stays silent for TIMEOUT cycles (legal range 2..255), the bus cycle is aborted with rsp_err set.
module wb_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_initiator_if.master bus,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    wb_req_t     req_q;
    logic [7:0]  wait_cnt;
    logic [31:0] rsp_dat_q;
    logic        rsp_err_q;
    logic        accept;
    logic        timeout_hit;

    assign accept      = bus.cmd_valid & bus.cmd_ready;
    assign timeout_hit = (wait_cnt == WAIT_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUS;
            // ack is checked before timeout, so an ack on the last allowed cycle still completes normally
            BUS:     if (bus.wbm_ack_i || timeout_hit) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_q     <= '0;
            wait_cnt  <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                req_q    <= '{we: bus.cmd_we, sel: bus.cmd_sel, adr: bus.cmd_adr, dat: bus.cmd_dat};
                wait_cnt <= '0;
            end
            // The response registers are written only in BUS. That keeps them frozen for all of RESP and makes a late ack harmless.
            if (state == BUS) begin
                if (bus.wbm_ack_i) begin
                    rsp_dat_q <= req_q.we ? 32'h0 : bus.wbm_dat_i;
                    rsp_err_q <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (timeout_hit) begin
                        rsp_dat_q <= 32'h0;
                        rsp_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Gate cmd_ready with reset so that no command can slip in on a reset edge.
    assign bus.cmd_ready = (state == IDLE) && !wb_rst_i;
    assign bus.wbm_cyc_o = (state == BUS);
    assign bus.wbm_stb_o = (state == BUS);
    assign bus.wbm_we_o  = req_q.we;
    assign bus.wbm_sel_o = req_q.sel;
    assign bus.wbm_adr_o = req_q.adr;
    assign bus.wbm_dat_o = req_q.dat;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state != IDLE);

endmodule
